// File: rtl/pu_seq.sv
// Run-control sequencer for the 16-bit PU: owns pca and walks each instruction
// through FETCH/DECODE/EXEC/WB, qualifying the register-file write strobe.
module pu_seq #(
    parameter int PC_W     = 6,
    parameter int IMEM_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic             stop,
    input  logic             halt,
    input  logic             dec_we,
    output logic [PC_W-1:0]  pca,
    output logic             ir_en,
    output logic             we,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] icount
);

    localparam int FW = (IMEM_LAT > 1) ? $clog2(IMEM_LAT) : 1;
    localparam logic [FW-1:0] FLAST = FW'(IMEM_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
    } state_t;

    state_t        state;
    logic [FW-1:0] fcnt;
    logic          run;
    logic          stop_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            pca       <= '0;
            icount    <= '0;
            fcnt      <= '0;
            run       <= 1'b0;
            stop_pend <= 1'b0;
        end else begin
            // Sticky stop; the WB branch below clears it when returning to IDLE.
            if (busy && stop)
                stop_pend <= 1'b1;
            case (state)
                S_IDLE: begin
                    stop_pend <= 1'b0;
                    if (start) begin
                        state <= S_FETCH;
                        run   <= 1'b1;
                    end else if (step) begin
                        state <= S_FETCH;
                        run   <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (fcnt == FLAST) begin
                        fcnt  <= '0;
                        state <= S_DECODE;
                    end else begin
                        fcnt <= fcnt + FW'(1);
                    end
                end
                S_DECODE: state <= halt ? S_HALT : S_EXEC;
                S_EXEC:   state <= S_WB;
                S_WB: begin
                    pca <= pca + PC_W'(1);
                    if (icount != '1)
                        icount <= icount + CNT_W'(1);
                    if (run && !stop_pend && !stop) begin
                        state <= S_FETCH;
                    end else begin
                        state     <= S_IDLE;
                        stop_pend <= 1'b0;
                    end
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode straight off the state register so an async reset clears them at once.
    always_comb begin
        busy   = (state == S_FETCH) || (state == S_DECODE) ||
                 (state == S_EXEC)  || (state == S_WB);
        halted = (state == S_HALT);
        ir_en  = (state == S_FETCH) && (fcnt == FLAST);
        we     = (state == S_WB) && dec_we;
    end

endmodule

// File: tb/tb_pu_seq.sv
// Directed bench for pu_seq: a default instance (PC_W=6, IMEM_LAT=1, CNT_W=16)
// and a narrow one (PC_W=2, IMEM_LAT=3, CNT_W=2) for wrap/latency/saturation.
module tb_pu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // default instance
    logic       rst0, start0, step0, stop0, halt0, dec_we0;
    logic [5:0] pca0;
    logic       ir_en0, we0, busy0, halted0;
    logic [15:0] icount0;

    // narrow instance
    logic       rst1, start1, step1, stop1, halt1, dec_we1;
    logic [1:0] pca1;
    logic       ir_en1, we1, busy1, halted1;
    logic [1:0] icount1;

    pu_seq u0 (
        .clk(clk), .rst(rst0), .start(start0), .step(step0), .stop(stop0),
        .halt(halt0), .dec_we(dec_we0), .pca(pca0), .ir_en(ir_en0), .we(we0),
        .busy(busy0), .halted(halted0), .icount(icount0)
    );

    pu_seq #(.PC_W(2), .IMEM_LAT(3), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst1), .start(start1), .step(step1), .stop(stop1),
        .halt(halt1), .dec_we(dec_we1), .pca(pca1), .ir_en(ir_en1), .we(we1),
        .busy(busy1), .halted(halted1), .icount(icount1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one rising edge, then land on the following falling edge for sampling
    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst0 = 1; start0 = 0; step0 = 0; stop0 = 0; halt0 = 0; dec_we0 = 0;
        rst1 = 1; start1 = 0; step1 = 0; stop1 = 0; halt1 = 0; dec_we1 = 0;
        cyc();

        // reset state
        chk("rst_pca", pca0, 0);
        chk("rst_icount", icount0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_halted", halted0, 0);
        chk("rst_we", we0, 0);
        chk("rst_ir_en", ir_en0, 0);
        rst0 = 0;
        cyc();
        chk("idle_busy", busy0, 0);

        // continuous run: one instruction every 4 cycles
        dec_we0 = 1; start0 = 1;
        cyc();
        start0 = 0;
        for (int i = 1; i <= 12; i++) begin
            chk($sformatf("run_we_c%0d", i), we0, (i % 4 == 0) ? 1 : 0);
            chk($sformatf("run_pca_c%0d", i), pca0, (i - 1) / 4);
            chk($sformatf("run_iren_c%0d", i), ir_en0, (i % 4 == 1) ? 1 : 0);
            cyc();
        end
        chk("run_icount_12", icount0, 3);
        chk("run_pca_3", pca0, 3);

        // stop raised for one cycle in EXEC of the instruction at pca=5
        for (int i = 13; i < 23; i++) cyc();
        chk("stop_pre_pca", pca0, 5);
        chk("stop_pre_busy", busy0, 1);
        stop0 = 1;
        cyc();
        stop0 = 0;
        chk("stop_wb_we", we0, 1);
        cyc();
        chk("stop_pca", pca0, 6);
        chk("stop_busy", busy0, 0);
        chk("stop_icount", icount0, 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("stop_no_iren_%0d", i), ir_en0, 0);
            cyc();
        end
        chk("stop_pca_hold", pca0, 6);

        // single step
        rst0 = 1;
        cyc();
        rst0 = 0;
        chk("step_rst_pca", pca0, 0);
        step0 = 1;
        cyc();
        step0 = 0;
        chk("step_fetch_busy", busy0, 1);
        chk("step_fetch_iren", ir_en0, 1);
        cyc(); cyc(); cyc();
        chk("step_wb_we", we0, 1);
        cyc();
        chk("step1_pca", pca0, 1);
        chk("step1_busy", busy0, 0);
        chk("step1_icount", icount0, 1);
        cyc();
        chk("step1_idle_we", we0, 0);
        chk("step1_idle_pca", pca0, 1);
        step0 = 1;
        cyc();
        step0 = 0;
        cyc(); cyc(); cyc(); cyc();
        chk("step2_pca", pca0, 2);
        chk("step2_icount", icount0, 2);
        chk("step2_busy", busy0, 0);

        // start and step together (start wins -> run), halt in DECODE at pca=3
        rst0 = 1;
        cyc();
        rst0 = 0;
        start0 = 1; step0 = 1;
        cyc();
        start0 = 0; step0 = 0;
        for (int i = 1; i < 14; i++) cyc();
        chk("halt_pre_pca", pca0, 3);
        halt0 = 1;
        cyc();
        halt0 = 0;
        chk("halt_halted", halted0, 1);
        chk("halt_busy", busy0, 0);
        chk("halt_pca", pca0, 3);
        chk("halt_icount", icount0, 3);
        chk("halt_we", we0, 0);
        start0 = 1; step0 = 1; stop0 = 1;
        cyc(); cyc(); cyc();
        start0 = 0; step0 = 0; stop0 = 0;
        chk("halt_hold_halted", halted0, 1);
        chk("halt_hold_pca", pca0, 3);
        chk("halt_hold_we", we0, 0);
        rst0 = 1;
        #1;
        chk("halt_rst_halted", halted0, 0);
        chk("halt_rst_pca", pca0, 0);
        cyc();
        rst0 = 0;
        cyc();
        chk("halt_rst_idle", busy0, 0);

        // narrow instance: pca wrap, 6 cycles/instr, icount saturation
        rst1 = 0;
        cyc();
        dec_we1 = 1; start1 = 1;
        cyc();
        start1 = 0;
        for (int i = 1; i <= 30; i++) begin
            chk($sformatf("n_pca_c%0d", i), pca1, ((i - 1) / 6) % 4);
            chk($sformatf("n_we_c%0d", i), we1, (i % 6 == 0) ? 1 : 0);
            chk($sformatf("n_iren_c%0d", i), ir_en1, (i % 6 == 3) ? 1 : 0);
            cyc();
        end
        chk("n_pca_wrap", pca1, 1);
        chk("n_icount_sat", icount1, 3);

        // async reset mid-FETCH
        cyc();
        chk("n_midfetch_busy", busy1, 1);
        rst1 = 1;
        #1;
        chk("n_rstf_busy", busy1, 0);
        chk("n_rstf_pca", pca1, 0);
        chk("n_rstf_icount", icount1, 0);
        chk("n_rstf_iren", ir_en1, 0);
        cyc();
        rst1 = 0;
        start1 = 1;
        cyc();
        start1 = 0;
        for (int i = 1; i < 6; i++) cyc();
        chk("n_wb_we", we1, 1);

        // async reset mid-WB kills the write strobe immediately
        rst1 = 1;
        #1;
        chk("n_rstw_we", we1, 0);
        chk("n_rstw_pca", pca1, 0);
        chk("n_rstw_icount", icount1, 0);
        cyc();
        chk("n_rstw_we_hold", we1, 0);
        rst1 = 0;
        cyc();
        chk("n_rstw_idle", busy1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
